input_debouncer: RTL and testbench

Conditions the raw board inputs (direction key, 4 speed switches) before they reach the speed and LED-control logic.
- Each input is synchronised, then debounced by a per-channel counter FSM.
- Produces clean levels plus single-cycle edge ticks.
- Sits between the board pins and the frequency-divider / direction-tick consumers, in the PLL clock domain.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_channel.sv | 105 ++++++++++
 rtl/input_debouncer.sv | 107 ++++++++++
 tb/tb_input_debouncer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer: per-channel FSM states and
// the synchroniser depth used by every debounce_channel instance.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, counter FSM, level + edge pulses.
// Ports: i_clk, i_rst_n (async low), i_raw (async pin), o_level, o_rise, o_fall.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (synced) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!synced) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!synced) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (synced) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces the direction key and N_SW speed switches into clean levels
// and one-cycle change ticks for the divider / direction-tick consumers.
// Ports: i_clk, i_rst_n (async low), i_dir, i_sw[N_SW] (async pins);
// o_dir_level, o_dir_tick, o_sw[N_SW], o_sw_changed.
// Optional macro DEBOUNCE_LONG_PRESS_EN adds LONG_CYCLES and o_dir_long.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned N_SW            = 4,
    parameter bit          DIR_ACTIVE_LOW  = 1'b1
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_CYCLES     = 50000000
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_dir,
    input  logic [N_SW-1:0] i_sw,
    output logic            o_dir_level,
    output logic            o_dir_tick,
    output logic [N_SW-1:0] o_sw,
    output logic            o_sw_changed
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    output logic            o_dir_long
`endif
);

    logic            dir_raw;
    logic            dir_fall;
    logic            dir_fall_unused;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    // Inverting ahead of the synchroniser keeps the zero reset state of
    // the sync flops equal to "not pressed", so an idle key held high at
    // reset release never walks the FSM through a spurious press.
    assign dir_raw = DIR_ACTIVE_LOW ? ~i_dir : i_dir;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dir (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_raw  (dir_raw),
        .o_level(o_dir_level),
        .o_rise (o_dir_tick),
        .o_fall (dir_fall)
    );

    // Release edges are not reported for the key.
    assign dir_fall_unused = dir_fall;

    for (genvar g = 0; g < int'(N_SW); g++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sw (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_raw  (i_sw[g]),
            .o_level(o_sw[g]),
            .o_rise (sw_rise[g]),
            .o_fall (sw_fall[g])
        );
    end

    // Rise/fall are flops inside each channel, so this OR lines up with
    // the o_sw update and merges simultaneous bit changes into one pulse.
    assign o_sw_changed = |(sw_rise | sw_fall);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Hold count saturates at HOLD_LAST, which limits the pulse to one
    // per press; release clears it for the next press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!o_dir_level) begin
            hold_d = '0;
        end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + HOLD_ONE;
            long_d = (hold_d == HOLD_LAST);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign o_dir_long = long_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (DEBOUNCE_CYCLES=4, active-low key).
// Long-press checks run when DEBOUNCE_LONG_PRESS_EN is defined.
module tb_input_debouncer;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_dir   = 1'b1;
    logic [3:0] i_sw    = 4'b0000;
    logic       o_dir_level;
    logic       o_dir_tick;
    logic [3:0] o_sw;
    logic       o_sw_changed;
`ifdef DEBOUNCE_LONG_PRESS_EN
    logic       o_dir_long;
`endif

    int n_checks    = 0;
    int n_fail      = 0;
    int n_dir_ticks = 0;
    int n_sw_pulses = 0;
    int n_long      = 0;

    input_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .N_SW           (4),
        .DIR_ACTIVE_LOW (1'b1)
`ifdef DEBOUNCE_LONG_PRESS_EN
        ,
        .LONG_CYCLES    (20)
`endif
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_dir       (i_dir),
        .i_sw        (i_sw),
        .o_dir_level (o_dir_level),
        .o_dir_tick  (o_dir_tick),
        .o_sw        (o_sw),
        .o_sw_changed(o_sw_changed)
`ifdef DEBOUNCE_LONG_PRESS_EN
        ,
        .o_dir_long  (o_dir_long)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_dir_tick) n_dir_ticks++;
        if (o_sw_changed) n_sw_pulses++;
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (o_dir_long) n_long++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        // reset, key idle (high), switches off
        tick(3);
        chk("rst_dir", 32'(o_dir_level), 0);
        chk("rst_sw", 32'(o_sw), 0);
        i_rst_n = 1'b1;
        tick(50);
        chk("idle_dir", 32'(o_dir_level), 0);
        chk("idle_sw", 32'(o_sw), 0);
        chk("idle_ticks", n_dir_ticks, 0);
        chk("idle_swchg", n_sw_pulses, 0);

        // clean press: level 6 edges after pin change
        i_dir = 1'b0;
        tick(5);
        chk("press_pre", 32'(o_dir_level), 0);
        tick(1);
        chk("press_lvl", 32'(o_dir_level), 1);
        chk("press_tick", 32'(o_dir_tick), 1);
        tick(1);
        chk("press_tick_off", 32'(o_dir_tick), 0);
        chk("press_hold", 32'(o_dir_level), 1);
        chk("press_ntick", n_dir_ticks, 1);

        // release: level drops after 6 edges, no tick
        i_dir = 1'b1;
        tick(5);
        chk("rel_pre", 32'(o_dir_level), 1);
        tick(1);
        chk("rel_lvl", 32'(o_dir_level), 0);
        tick(4);
        chk("rel_ntick", n_dir_ticks, 1);

        // bounce: low 3, high 1, then low steady
        i_dir = 1'b0;
        tick(3);
        i_dir = 1'b1;
        tick(1);
        i_dir = 1'b0;
        chk("bounce_quiet", 32'(o_dir_level), 0);
        tick(5);
        chk("bounce_pre", 32'(o_dir_level), 0);
        tick(1);
        chk("bounce_lvl", 32'(o_dir_level), 1);
        chk("bounce_tick", 32'(o_dir_tick), 1);
        tick(3);
        chk("bounce_ntick", n_dir_ticks, 2);

        // two switches together -> single change pulse
        i_sw = 4'b0101;
        tick(5);
        chk("sw_pre", 32'(o_sw), 0);
        tick(1);
        chk("sw_set", 32'(o_sw), 32'h5);
        chk("sw_chg", 32'(o_sw_changed), 1);
        tick(1);
        chk("sw_chg_off", 32'(o_sw_changed), 0);
        chk("sw_npulse", n_sw_pulses, 1);

        // 2-cycle glitch on sw[0] is rejected
        i_sw[0] = 1'b0;
        tick(2);
        i_sw[0] = 1'b1;
        tick(10);
        chk("sw_glitch", 32'(o_sw), 32'h5);
        chk("sw_glitch_np", n_sw_pulses, 1);

        // reset mid WAIT_HI (cnt=2)
        i_dir = 1'b1;
        tick(10);
        chk("pre_rst_dir", 32'(o_dir_level), 0);
        i_dir = 1'b0;
        tick(4);
        chk("wait_dir", 32'(o_dir_level), 0);
        i_rst_n = 1'b0;
        #1;
        chk("rst_async_sw", 32'(o_sw), 0);
        chk("rst_async_dir", 32'(o_dir_level), 0);
        tick(2);
        i_rst_n = 1'b1;
        tick(5);
        chk("rst2_pre", 32'(o_dir_level), 0);
        tick(1);
        chk("rst2_lvl", 32'(o_dir_level), 1);
        chk("rst2_tick", 32'(o_dir_tick), 1);
        chk("rst2_sw", 32'(o_sw), 32'h5);
        chk("rst2_swchg", 32'(o_sw_changed), 1);
        tick(1);
        chk("rst2_ntick", n_dir_ticks, 3);

`ifdef DEBOUNCE_LONG_PRESS_EN
        // level rose one edge ago; long pulse due 19 edges after rise
        tick(17);
        chk("long_pre", 32'(o_dir_long), 0);
        chk("long_pre_n", n_long, 0);
        tick(1);
        chk("long_pulse", 32'(o_dir_long), 1);
        tick(25);
        chk("long_once", n_long, 1);
        i_dir = 1'b1;
        tick(10);
        chk("long_rel", 32'(o_dir_level), 0);
        // short press: level high 16 edges only
        i_dir = 1'b0;
        tick(6);
        chk("short_lvl", 32'(o_dir_level), 1);
        tick(10);
        i_dir = 1'b1;
        tick(20);
        chk("short_nolong", n_long, 1);
        chk("short_rel", 32'(o_dir_level), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
